// File: rtl/fetch_sched.sv
// Job scheduler for the address fetcher: latches a job, strobes one address per
// unstalled cycle, waits out the fetch pipeline, then pulses done. Optional stall
// performance counter is built only when FETCH_SCHED_PERF_EN is defined.
module fetch_sched #(
  parameter int WORD_ADDR_BITS = 16,
  parameter int DATA_MAX_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WORD_ADDR_BITS-1:0]    cfg_src_addr,
  input  logic [DATA_MAX_BITS-1:0]     cfg_channel,
  input  logic [DATA_MAX_BITS-1:0]     cfg_row,
  input  logic                         stall,
  input  logic                         fetch_data_NA,
  output logic                         fetch_data_ready,
  output logic                         fetch_en,
  output logic [WORD_ADDR_BITS-1:0]    fetch_src_addr,
  output logic [DATA_MAX_BITS-1:0]     fetch_channel,
  output logic [DATA_MAX_BITS-1:0]     fetch_row,
  output logic                         fetch_ch_rst,
  output logic                         fetch_row_rst,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [2*DATA_MAX_BITS-1:0]   issued_cnt,
  output logic [15:0]                  perf_stall_cnt
);

  localparam int CW = 2 * DATA_MAX_BITS;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t       state;
  logic         drain_cnt;
  logic         err_q;
  logic [CW-1:0] total;
  logic         last_issue;

  // Widen both operands first so the product keeps all 2*DATA_MAX_BITS bits.
  assign total = CW'(fetch_channel) * CW'(fetch_row);

  // Abort suppresses the strobe in its own cycle so issued_cnt matches the strobes seen.
  assign fetch_en   = (state == RUN) && !stall && !abort;
  assign last_issue = fetch_en && ((issued_cnt + CW'(1)) == total);

  assign busy             = (state == LOAD) || (state == RUN) || (state == DRAIN);
  assign fetch_data_ready = (state == RUN) || (state == DRAIN);
  assign fetch_ch_rst     = (state == LOAD);
  assign fetch_row_rst    = (state == LOAD);
  assign done             = (state == DONE);
  assign err              = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      drain_cnt      <= 1'b0;
      err_q          <= 1'b0;
      issued_cnt     <= '0;
      fetch_src_addr <= '0;
      fetch_channel  <= '0;
      fetch_row      <= '0;
    end else begin
      err_q <= 1'b0;
      if (abort) begin
        if (state != IDLE) state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              fetch_src_addr <= cfg_src_addr;
              fetch_channel  <= cfg_channel;
              fetch_row      <= cfg_row;
              issued_cnt     <= '0;
              state          <= LOAD;
            end
          end
          LOAD: begin
            if (fetch_channel == '0 || fetch_row == '0) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            if (fetch_en) issued_cnt <= issued_cnt + CW'(1);
            if (last_issue || fetch_data_NA) begin
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end
          end
          DRAIN: begin
            // Two cycles: fetcher address register, then SRAM read.
            if (drain_cnt) state <= DONE;
            else           drain_cnt <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_SCHED_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (state == LOAD) begin
      perf_q <= '0;
    end else if (state == RUN && stall && perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: one task per scenario, cycle k counted from the
// edge that samples start (k=1 is LOAD).
module tb_fetch_sched;

  logic        clk, rst, start, abort, stall, fetch_data_NA;
  logic [15:0] cfg_src_addr;
  logic [7:0]  cfg_channel, cfg_row;
  logic        fetch_data_ready, fetch_en, fetch_ch_rst, fetch_row_rst, busy, done, err;
  logic [15:0] fetch_src_addr;
  logic [7:0]  fetch_channel, fetch_row;
  logic [15:0] issued_cnt, perf_stall_cnt;

  int checks = 0;
  int passed = 0;

  fetch_sched #(.WORD_ADDR_BITS(16), .DATA_MAX_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src_addr(cfg_src_addr), .cfg_channel(cfg_channel), .cfg_row(cfg_row),
    .stall(stall), .fetch_data_NA(fetch_data_NA),
    .fetch_data_ready(fetch_data_ready), .fetch_en(fetch_en),
    .fetch_src_addr(fetch_src_addr), .fetch_channel(fetch_channel), .fetch_row(fetch_row),
    .fetch_ch_rst(fetch_ch_rst), .fetch_row_rst(fetch_row_rst),
    .busy(busy), .done(done), .err(err),
    .issued_cnt(issued_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a job and let the sampling edge pass; afterwards the DUT is in cycle k=1.
  task automatic start_job(input logic [15:0] src, input logic [7:0] ch, input logic [7:0] row);
    cfg_src_addr = src;
    cfg_channel  = ch;
    cfg_row      = row;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Step cycles k0.. until done or budget; stall held in [s_lo,s_hi], NA pulsed at na_k.
  task automatic run_until_done(input int k0, input int max_k, input int s_lo, input int s_hi,
                                input int na_k, output int en_cnt, output int first_en,
                                output int done_at, output logic [31:0] en_mask,
                                output logic ready_at_done);
    en_cnt = 0; first_en = -1; done_at = -1; en_mask = '0; ready_at_done = 1'b1;
    for (int k = k0; k <= max_k && done_at < 0; k++) begin
      tick();
      stall         = (k >= s_lo) && (k <= s_hi);
      fetch_data_NA = (k == na_k);
      #1;
      if (fetch_en) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        if (k < 32) en_mask[k] = 1'b1;
      end
      if (done) begin
        done_at       = k;
        ready_at_done = fetch_data_ready;
      end
    end
    stall         = 1'b0;
    fetch_data_NA = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; fetch_data_NA = 1'b0;
    cfg_src_addr = 16'hFFFF; cfg_channel = 8'hFF; cfg_row = 8'hFF;
    tick(); tick();
    checks++; if ({busy, done, err, fetch_en, fetch_data_ready, fetch_ch_rst} !== 6'b0)
      $display("FAIL reset_flags got %b exp 000000", {busy, done, err, fetch_en, fetch_data_ready, fetch_ch_rst}); else passed++;
    checks++; if (issued_cnt !== 16'd0) $display("FAIL reset_issued got %0d exp 0", issued_cnt); else passed++;
    checks++; if (perf_stall_cnt !== 16'd0) $display("FAIL reset_perf got %0d exp 0", perf_stall_cnt); else passed++;
    checks++; if ({fetch_src_addr, fetch_channel, fetch_row} !== 32'd0)
      $display("FAIL reset_params got %h exp 0", {fetch_src_addr, fetch_channel, fetch_row}); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int en_cnt, first_en, done_at; logic [31:0] mask; logic rdy;
    start_job(16'h1234, 8'd3, 8'd4);
    checks++; if ({busy, fetch_ch_rst, fetch_row_rst, fetch_en, fetch_data_ready} !== 5'b11100)
      $display("FAIL basic_load_flags got %b exp 11100", {busy, fetch_ch_rst, fetch_row_rst, fetch_en, fetch_data_ready}); else passed++;
    checks++; if ({fetch_src_addr, fetch_channel, fetch_row} !== {16'h1234, 8'd3, 8'd4})
      $display("FAIL basic_latch got %h exp 12340304", {fetch_src_addr, fetch_channel, fetch_row}); else passed++;
    run_until_done(2, 40, -1, -1, -1, en_cnt, first_en, done_at, mask, rdy);
    checks++; if (first_en !== 2) $display("FAIL basic_latency got %0d exp 2", first_en); else passed++;
    checks++; if (en_cnt !== 12) $display("FAIL basic_en_cycles got %0d exp 12", en_cnt); else passed++;
    checks++; if (issued_cnt !== 16'd12) $display("FAIL basic_issued got %0d exp 12", issued_cnt); else passed++;
    checks++; if (done_at + 1 !== 17) $display("FAIL basic_done_cycle got %0d exp 17", done_at + 1); else passed++;
    checks++; if (rdy !== 1'b0) $display("FAIL basic_ready_in_done got %b exp 0", rdy); else passed++;
    tick();
    checks++; if ({busy, done, fetch_data_ready} !== 3'b000)
      $display("FAIL basic_after_done got %b exp 000", {busy, done, fetch_data_ready}); else passed++;
  endtask

  task automatic test_stall();
    int en_cnt, first_en, done_at; logic [31:0] mask; logic rdy;
    start_job(16'h0040, 8'd2, 8'd2);
    // RUN starts at k=2; its 3rd..5th cycles (k=4..6) are stalled.
    run_until_done(2, 40, 4, 6, -1, en_cnt, first_en, done_at, mask, rdy);
    checks++; if (mask !== 32'h0000_018C) $display("FAIL stall_en_pattern got %h exp 0000018c", mask); else passed++;
    checks++; if (issued_cnt !== 16'd4) $display("FAIL stall_issued got %0d exp 4", issued_cnt); else passed++;
    checks++; if (done_at !== 11) $display("FAIL stall_done_k got %0d exp 11", done_at); else passed++;
`ifdef FETCH_SCHED_PERF_EN
    checks++; if (perf_stall_cnt !== 16'd3) $display("FAIL stall_perf got %0d exp 3", perf_stall_cnt); else passed++;
`else
    checks++; if (perf_stall_cnt !== 16'd0) $display("FAIL stall_perf got %0d exp 0", perf_stall_cnt); else passed++;
`endif
    tick();
  endtask

  task automatic test_zero_dim();
    logic any_bad;
    start_job(16'h0100, 8'd5, 8'd0);
    tick();
    checks++; if ({err, busy, fetch_en} !== 3'b100) $display("FAIL zero_err_pulse got %b exp 100", {err, busy, fetch_en}); else passed++;
    checks++; if (issued_cnt !== 16'd0) $display("FAIL zero_issued got %0d exp 0", issued_cnt); else passed++;
    any_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (err || done || fetch_en || busy) any_bad = 1'b1;
    end
    checks++; if (any_bad !== 1'b0) $display("FAIL zero_quiet got %b exp 0", any_bad); else passed++;
  endtask

  task automatic test_abort();
    logic any_bad;
    start_job(16'h0200, 8'd3, 8'd4);
    for (int k = 2; k <= 6; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, fetch_data_ready, fetch_en, done} !== 4'b0000)
      $display("FAIL abort_idle got %b exp 0000", {busy, fetch_data_ready, fetch_en, done}); else passed++;
    checks++; if (issued_cnt !== 16'd4) $display("FAIL abort_issued got %0d exp 4", issued_cnt); else passed++;
    any_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || fetch_en || busy || issued_cnt != 16'd4) any_bad = 1'b1;
    end
    checks++; if (any_bad !== 1'b0) $display("FAIL abort_no_done got %b exp 0", any_bad); else passed++;
  endtask

  task automatic test_na();
    int en_cnt, first_en, done_at; logic [31:0] mask; logic rdy;
    start_job(16'h0300, 8'd3, 8'd4);
    run_until_done(2, 40, -1, -1, 4, en_cnt, first_en, done_at, mask, rdy);
    checks++; if (issued_cnt !== 16'd3) $display("FAIL na_issued got %0d exp 3", issued_cnt); else passed++;
    checks++; if (done_at !== 7) $display("FAIL na_done_k got %0d exp 7", done_at); else passed++;
    tick();
  endtask

  task automatic test_busy_ignore();
    int en_cnt, first_en, done_at; logic [31:0] mask; logic rdy;
    start_job(16'h0400, 8'd3, 8'd4);
    tick(); tick(); tick();
    cfg_channel = 8'd1; cfg_row = 8'd1; cfg_src_addr = 16'hBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({fetch_src_addr, fetch_channel, fetch_row, busy} !== {16'h0400, 8'd3, 8'd4, 1'b1})
      $display("FAIL busy_cfg_hold got %h exp 0400 03 04 busy", {fetch_src_addr, fetch_channel, fetch_row}); else passed++;
    run_until_done(6, 40, -1, -1, -1, en_cnt, first_en, done_at, mask, rdy);
    checks++; if (done_at !== 16 || issued_cnt !== 16'd12)
      $display("FAIL busy_job_intact got done_k %0d issued %0d exp 16 12", done_at, issued_cnt); else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({busy, fetch_ch_rst} !== 2'b00) $display("FAIL done_start_ignored got %b exp 00", {busy, fetch_ch_rst}); else passed++;
    tick();
  endtask

  task automatic test_large();
    int en_cnt, first_en, done_at; logic [31:0] mask; logic rdy;
    start_job(16'h0500, 8'd255, 8'd255);
    run_until_done(2, 70000, -1, -1, -1, en_cnt, first_en, done_at, mask, rdy);
    checks++; if (en_cnt !== 65025) $display("FAIL large_en_cycles got %0d exp 65025", en_cnt); else passed++;
    checks++; if (issued_cnt !== 16'd65025) $display("FAIL large_issued got %0d exp 65025", issued_cnt); else passed++;
    checks++; if (done_at + 1 !== 65030) $display("FAIL large_done_cycle got %0d exp 65030", done_at + 1); else passed++;
    tick();
  endtask

  task automatic test_reset_in_drain();
    int en_cnt, first_en, done_at; logic [31:0] mask; logic rdy; logic any_bad;
    start_job(16'h0600, 8'd2, 8'd3);
    for (int k = 2; k <= 8; k++) tick();
    checks++; if ({busy, fetch_data_ready, fetch_en} !== 3'b110)
      $display("FAIL drain_state got %b exp 110", {busy, fetch_data_ready, fetch_en}); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, fetch_data_ready, fetch_en, done, err, issued_cnt, fetch_channel, fetch_src_addr} !== '0)
      $display("FAIL drain_reset_now got busy %b rdy %b issued %0d ch %0d", busy, fetch_data_ready, issued_cnt, fetch_channel); else passed++;
    tick(); tick();
    rst = 1'b1;
    any_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || err || busy) any_bad = 1'b1;
    end
    checks++; if (any_bad !== 1'b0) $display("FAIL drain_reset_silent got %b exp 0", any_bad); else passed++;
    start_job(16'h0700, 8'd2, 8'd3);
    run_until_done(2, 40, -1, -1, -1, en_cnt, first_en, done_at, mask, rdy);
    checks++; if (en_cnt !== 6 || issued_cnt !== 16'd6 || done_at !== 10)
      $display("FAIL drain_rerun got en %0d issued %0d done_k %0d exp 6 6 10", en_cnt, issued_cnt, done_at); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_dim();
    test_abort();
    test_na();
    test_busy_ignore();
    test_large();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on posedge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: start  input  1  job request; sampled only in IDLE.
REQ-004 SHALL: abort  input  1  synchronous job cancel; sampled in any state.
REQ-005 SHALL: cfg_src_addr  input  WORD_ADDR_BITS  job base word address.
REQ-006 SHALL: cfg_channel  input  DATA_MAX_BITS  channel count of the job.
REQ-007 SHALL: cfg_row  input  DATA_MAX_BITS  rows per channel.
REQ-008 SHALL: stall  input  1  downstream backpressure; 1 = hold issue.
REQ-009 SHALL: fetch_data_NA  input  1  fetcher end-of-sweep flag.
REQ-010 SHALL: fetch_data_ready  output  1  fetcher enable; low = fetcher index reset.
REQ-011 SHALL: fetch_en  output  1  per-cycle address-issue strobe to fetcher.
REQ-012 SHALL: fetch_src_addr / fetch_channel / fetch_row  output  WORD_ADDR_BITS / DATA_MAX_BITS / DATA_MAX_BITS  latched job parameters.
REQ-013 SHALL: fetch_ch_rst, fetch_row_rst  output  1 each  fetcher index clears.
REQ-014 SHALL: busy  output  1  high in LOAD, RUN, DRAIN.
REQ-015 SHALL: done  output  1  one-cycle pulse on job completion.
REQ-016 SHALL: err  output  1  one-cycle pulse on zero-dimension job.
REQ-017 SHALL: issued_cnt  output  2*DATA_MAX_BITS  addresses issued in current/last job.
REQ-018 SHALL: perf_stall_cnt  output  16  stall cycles during RUN (see Configuration).

Function
REQ-019 SHALL: states IDLE, LOAD, RUN, DRAIN, DONE; encoding implementer's choice.
REQ-020 SHALL: IDLE + start=1 -> LOAD next cycle; cfg_* latched into fetch_* registers on that edge; issued_cnt cleared.
REQ-021 SHALL: LOAD: if latched channel==0 or row==0 -> err pulse for one cycle, return to IDLE; else -> RUN; fetch_ch_rst=fetch_row_rst=1 during LOAD only.
REQ-022 SHALL: RUN: fetch_data_ready=1; fetch_en = ~stall; issued_cnt increments on every cycle with fetch_en=1.
REQ-023 SHALL: total = fetch_channel*fetch_row computed at full 2*DATA_MAX_BITS width, no truncation.
REQ-024 SHALL: RUN -> DRAIN on the edge where issued_cnt reaches total (last issue cycle); fetch_en low from DRAIN onward.
REQ-025 SHALL: fetch_data_NA=1 while in RUN before count reached -> treated as completion, RUN -> DRAIN.
REQ-026 SHALL: DRAIN lasts exactly 2 cycles (fetcher address latency 1 + SRAM read 1), fetch_data_ready held 1, then -> DONE.
REQ-027 SHALL: DONE: done=1 one cycle, fetch_data_ready=0, then -> IDLE; start in DONE ignored.
REQ-028 SHALL: start while busy ignored; cfg_* changes while busy have no effect.
REQ-029 SHALL: abort=1 in any non-IDLE state -> IDLE next cycle, fetch_data_ready=0, fetch_en=0, no done, issued_cnt retained; abort has priority over start and all transitions.
REQ-030 SHALL: latency start-to-first-fetch_en = 2 cycles with stall=0; job of N addresses with no stall completes done at cycle N+5 after start.

Reset
REQ-031 SHALL: rst=0 -> state IDLE; all outputs and registers 0, including issued_cnt and perf_stall_cnt.
REQ-032 SHALL: reset mid-job abandons the job silently; no done/err pulse after release.

Configuration
REQ-033 SHALL: macro FETCH_SCHED_PERF_EN defined -> perf_stall_cnt increments on each RUN cycle with stall=1, saturates at 16'hFFFF, clears on LOAD.
REQ-034 SHALL: macro undefined -> perf_stall_cnt tied to 0, no counter logic.

Verification
REQ-035 SHALL: start, channel=3, row=4, stall=0 -> 12 fetch_en cycles, issued_cnt=12, done at cycle 17, busy low after.
REQ-036 SHALL: channel=2, row=2, stall high cycles 3-5 of RUN -> fetch_en gaps match, issued_cnt=4, perf_stall_cnt=3 (PERF_EN), done delayed 3 cycles.
REQ-037 SHALL: start with row=0 -> err one cycle after LOAD, no fetch_en, no done, returns IDLE.
REQ-038 SHALL: abort in 5th RUN cycle of 3x4 job -> IDLE next cycle, fetch_data_ready=0, issued_cnt=4 or 5 per abort edge, no done.
REQ-039 SHALL: channel=255, row=255 -> issued_cnt reaches 65025 without overflow, done asserted.
REQ-040 SHALL: rst asserted in DRAIN -> all outputs 0 immediately; next start runs full job normally.
